i2s_transmitter: RTL and testbench

Single-clock I2S master transmitter, the playback-side counterpart of the microphone receiver path. Accepts stereo PCM frames over a valid/ready handshake into a one-entry holding buffer. Generates i2s_clk and i2s_ws from the system clock and serialises the samples MSB-first on i2s_sd in standard I2S format, with a one-bit delay after each WS edge. Sits between a playback FIFO (fed by SPI) and the DAC/codec pins.

---
 rtl/i2s_transmitter.sv | 110 +++++++++++
 tb/tb_i2s_transmitter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: I2S master transmitter with a one-entry stereo frame buffer.
// Define I2S_TX_HOLD_LAST_EN to repeat the previous frame on underrun instead of sending zeros.
module i2s_transmitter #(
  parameter int DATA_SIZE = 16,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic [DATA_SIZE-1:0] sample_left,
  input  logic [DATA_SIZE-1:0] sample_right,
  output logic                 i2s_clk,
  output logic                 i2s_ws,
  output logic                 i2s_sd,
  output logic                 frame_start,
  output logic                 underrun,
  output logic [15:0]          underrun_count
);
  localparam int FW = 2 * SLOT_BITS;
  localparam int BW = $clog2(FW);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] b;
  logic [BW:0] nb;
  logic running, buf_full, tc, count_en, fall_tick, last_bit, wrap, ws_n;
  logic [DATA_SIZE-1:0] buf_l, buf_r, src_l, src_r;
  logic [FW-1:0] sh, ld;
  assign count_en = running | enable;
  assign tc = div_cnt == DW'(CLK_DIV - 1);
  assign fall_tick = count_en & tc & i2s_clk;
  assign last_bit = b == BW'(FW - 1);
  assign wrap = fall_tick & last_bit & enable;
  assign sample_ready = ~buf_full;
  assign nb = (BW+1)'(b) + 1'b1;
  // WS switches one bit ahead of each slot's MSB
  assign ws_n = nb >= (BW+1)'(SLOT_BITS - 1) && nb <= (BW+1)'(FW - 2);
`ifdef I2S_TX_HOLD_LAST_EN
  logic [DATA_SIZE-1:0] last_l, last_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_l <= '0;
      last_r <= '0;
    end else if (wrap && buf_full) begin
      last_l <= buf_l;
      last_r <= buf_r;
    end
  assign src_l = buf_full ? buf_l : last_l;
  assign src_r = buf_full ? buf_r : last_r;
`else
  assign src_l = buf_full ? buf_l : '0;
  assign src_r = buf_full ? buf_r : '0;
`endif
  always_comb begin
    ld = '0;
    ld[FW-1 -: DATA_SIZE] = src_l;
    ld[SLOT_BITS-1 -: DATA_SIZE] = src_r;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt        <= '0;
      i2s_clk        <= 1'b0;
      b              <= BW'(FW - 1);
      running        <= 1'b0;
      i2s_ws         <= 1'b0;
      i2s_sd         <= 1'b0;
      sh             <= '0;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      buf_full       <= 1'b0;
      buf_l          <= '0;
      buf_r          <= '0;
    end else begin
      frame_start <= wrap;
      underrun    <= wrap & ~buf_full;
      if (!count_en) begin
        div_cnt <= '0;
        i2s_clk <= 1'b0;
      end else begin
        div_cnt <= tc ? '0 : div_cnt + 1'b1;
        if (tc) i2s_clk <= ~i2s_clk;
      end
      if (fall_tick && last_bit) begin
        running <= enable;
        i2s_ws  <= 1'b0;
        i2s_sd  <= enable & ld[FW-1];
        if (enable) begin
          b  <= '0;
          sh <= ld << 1;
        end
      end else if (fall_tick) begin
        b      <= b + 1'b1;
        i2s_ws <= ws_n;
        i2s_sd <= sh[FW-1];
        sh     <= sh << 1;
      end
      if (wrap && buf_full) begin
        buf_full <= 1'b0;
      end else if (sample_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_l    <= sample_left;
        buf_r    <= sample_right;
      end
      if (wrap && !buf_full && underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 16'd1;
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: scoreboard bench; accepted frames are queued with their acceptance cycle and a
// monitor compares each serialised frame, underrun flag and underrun count against the queue.
module tb_i2s_transmitter;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, sample_valid = 1'b0;
  logic [15:0] sample_left = '0, sample_right = '0;
  logic sample_ready, i2s_clk, i2s_ws, i2s_sd, frame_start, underrun;
  logic [15:0] underrun_count;
  i2s_transmitter #(.DATA_SIZE(16), .SLOT_BITS(32), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_left(sample_left), .sample_right(sample_right),
    .i2s_clk(i2s_clk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd), .frame_start(frame_start),
    .underrun(underrun), .underrun_count(underrun_count));
  always #5 clk = ~clk;
  typedef struct {int stamp; logic [15:0] l; logic [15:0] r;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, fs_count = 0, k = 0;
  logic collecting = 1'b0, prev_clk = 1'b0, exp_ur;
  logic [15:0] mcnt = '0;
  logic [31:0] cur, last_lr = '0;
  logic [63:0] sdw, wsw;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction
  always @(posedge clk) cyc++;
  // monitor: frame boundaries pop the scoreboard, rising bit-clock edges collect the frame
  always @(negedge clk) begin
    if (!rst_n) begin
      collecting = 1'b0;
      prev_clk = 1'b0;
      mcnt = '0;
      last_lr = '0;
      k = 0;
    end else begin
      if (frame_start) begin
        exp_t e;
        fs_count++;
        exp_ur = !(q.size() > 0 && q[0].stamp < cyc);
        if (exp_ur) begin
          mcnt = (mcnt == 16'hFFFF) ? mcnt : mcnt + 16'd1;
`ifdef I2S_TX_HOLD_LAST_EN
          cur = last_lr;
`else
          cur = '0;
`endif
        end else begin
          e = q.pop_front();
          cur = {e.l, e.r};
          last_lr = cur;
        end
        chk("underrun_flag", 64'(underrun), 64'(exp_ur));
        chk("underrun_count", 64'(underrun_count), 64'(mcnt));
        collecting = 1'b1;
        k = 0;
      end
      if (collecting && i2s_clk && !prev_clk) begin
        sdw[63-k] = i2s_sd;
        wsw[63-k] = i2s_ws;
        k++;
        if (k == 64) begin
          collecting = 1'b0;
          chk("frame_sd", sdw, {cur[31:16], 16'h0, cur[15:0], 16'h0});
          chk("frame_ws", wsw, 64'h0000_0001_FFFF_FFFE);
        end
      end
      prev_clk = i2s_clk;
    end
  end
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    sample_valid = 1'b1;
    sample_left = l;
    sample_right = r;
    while (!sample_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) begin
      chk("send_timeout", 64'(n), 64'd0);
      sample_valid = 1'b0;
      return;
    end
    q.push_back('{cyc + 1, l, r});
    @(negedge clk);
    sample_valid = 1'b0;
    chk("ready_after_accept", 64'(sample_ready), 64'd0);
  endtask
  task automatic wait_fs(input int n);
    int t = fs_count + n;
    int c = 0;
    while (fs_count < t && c < 1000 * n) begin
      @(negedge clk);
      c++;
    end
    if (fs_count < t) chk("frame_start_timeout", 64'(fs_count), 64'(t));
  endtask
  task automatic wait_bit(input int kk);
    int c = 0;
    while (!(collecting && k >= kk) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 1000) chk("bit_wait_timeout", 64'(k), 64'(kk));
  endtask
  task automatic start_and_time();
    int n = 0;
    enable = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    chk("first_frame_latency", 64'(n), 64'd4);
  endtask
  task automatic check_reset_outputs();
    chk("rst_i2s_clk", 64'(i2s_clk), 64'd0);
    chk("rst_ws", 64'(i2s_ws), 64'd0);
    chk("rst_sd", 64'(i2s_sd), 64'd0);
    chk("rst_ready", 64'(sample_ready), 64'd1);
    chk("rst_frame_start", 64'(frame_start), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_count", 64'(underrun_count), 64'd0);
  endtask
  initial begin
    int hi_seen, fs0, c;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    send(16'hA5C3, 16'h1234);
    start_and_time();
    send(16'h8001, 16'h7FFE);
    wait_fs(1);
    wait_fs(3);
    send(16'h0001, 16'hFFFF);
    send(16'h8000, 16'h0000);
    send(16'h5555, 16'hAAAA);
    send(16'hF00D, 16'h0BAD);
    send(16'hBEEF, 16'h0F0F);
    wait_fs(1);
    wait_bit(10);
    enable = 1'b0;
    c = 0;
    while (collecting && c < 1000) begin
      @(negedge clk);
      c++;
    end
    repeat (8) @(negedge clk);
    fs0 = fs_count;
    hi_seen = 0;
    repeat (600) begin
      @(negedge clk);
      if (i2s_clk || i2s_ws || i2s_sd) hi_seen++;
    end
    chk("stopped_no_frame", 64'(fs_count), 64'(fs0));
    chk("stopped_pins_low", 64'(hi_seen), 64'd0);
    chk("stopped_ready", 64'(sample_ready), 64'd1);
    send(16'hCAFE, 16'h5A5A);
    start_and_time();
    send(16'h1111, 16'h2222);
    wait_bit(20);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs();
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(1);
    @(negedge clk);
    force dut.underrun_count = 16'hFFFD;
    mcnt = 16'hFFFD;
    @(negedge clk);
    release dut.underrun_count;
    wait_fs(3);
    c = 0;
    while (collecting && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("count_saturated", 64'(underrun_count), 64'hFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
